// File: rtl/async_mmap_read_stream.sv
// async_mmap_read_stream: issue count sequential word reads to async_mmap and stream returned words in order, capping reads in flight
module async_mmap_read_stream #(
  parameter int AddrWidth = 64,
  parameter int DataWidth = 512,
  parameter int DataWidthBytesLog = 6,
  parameter int CountWidth = 32,
  parameter int MaxOutstanding = 64,
  parameter int OutstandingWidth = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [AddrWidth-1:0]  base_addr,
  input  logic [CountWidth-1:0] count,
  output logic                  busy,
  output logic                  done,
  output logic [AddrWidth-1:0]  read_addr_din,
  output logic                  read_addr_write,
  input  logic                  read_addr_full_n,
  input  logic [DataWidth-1:0]  read_data_dout,
  input  logic                  read_data_empty_n,
  output logic                  read_data_read,
  output logic [DataWidth-1:0]  out_din,
  output logic                  out_write,
  input  logic                  out_full_n
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state_q, state_d;
  logic [AddrWidth-1:0] base_q, base_d;
  logic [CountWidth-1:0] cnt_q, cnt_d, issued_q, issued_d, received_q, received_d;
  logic [OutstandingWidth-1:0] outstanding_q, outstanding_d;
  logic run;
  always_comb begin
    run = state_q == RUN;
    busy = run;
    done = state_q == FIN;
    read_addr_write = run && issued_q != cnt_q && read_addr_full_n &&
                      outstanding_q != OutstandingWidth'(MaxOutstanding);
    read_data_read = run && read_data_empty_n && out_full_n;
    out_write = read_data_read;
    out_din = read_data_dout;
    read_addr_din = base_q + (AddrWidth'(issued_q) << DataWidthBytesLog);
    base_d = base_q;
    cnt_d = cnt_q;
    issued_d = issued_q + CountWidth'(read_addr_write);
    received_d = received_q + CountWidth'(read_data_read);
    outstanding_d = outstanding_q + OutstandingWidth'(read_addr_write) - OutstandingWidth'(read_data_read);
    state_d = done ? IDLE : (run && received_d == cnt_q) ? FIN : state_q;
    if (state_q == IDLE && start) begin
      base_d = base_addr;
      cnt_d = count;
      issued_d = '0;
      received_d = '0;
      outstanding_d = '0;
      state_d = count == '0 ? FIN : RUN;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q <= '0;
      cnt_q <= '0;
      issued_q <= '0;
      received_q <= '0;
      outstanding_q <= '0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      cnt_q <= cnt_d;
      issued_q <= issued_d;
      received_q <= received_d;
      outstanding_q <= outstanding_d;
    end
  end
endmodule

// File: tb/tb_async_mmap_read_stream.sv
// tb_async_mmap_read_stream: randomized scoreboard bench with an mmap read-port emulator
module tb_async_mmap_read_stream;
  logic clk = 0;
  logic rst = 1;
  logic start = 0;
  logic [63:0] base_addr = '0;
  logic [31:0] count = '0;
  logic busy, done, read_addr_write, read_data_read, out_write;
  logic [63:0] read_addr_din;
  logic [511:0] out_din;
  logic read_addr_full_n = 0;
  logic [511:0] read_data_dout = '0;
  logic read_data_empty_n = 0;
  logic out_full_n = 0;
  int checks = 0, failures = 0;
  int af_mode = 1, of_mode = 1, rd_mode = 1;
  int rel_cnt = 0, rel_used = 0;
  int n_issue = 0, n_beat = 0, n_done = 0, outst = 0;
  logic [31:0] xfer_cnt = '0;
  logic tog = 0, prev_ow = 0;
  logic [63:0] pending[$];
  logic [511:0] rdq[$];
  logic [63:0] exp_addr[$];
  logic [511:0] exp_data[$];

  async_mmap_read_stream dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .busy(busy), .done(done), .read_addr_din(read_addr_din), .read_addr_write(read_addr_write),
    .read_addr_full_n(read_addr_full_n), .read_data_dout(read_data_dout),
    .read_data_empty_n(read_data_empty_n), .read_data_read(read_data_read),
    .out_din(out_din), .out_write(out_write), .out_full_n(out_full_n)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] dat(input logic [63:0] a);
    return {8{a}};
  endfunction

  function automatic logic mv(input int m);
    return m == 0 ? 1'b0 : m == 1 ? 1'b1 : m == 2 ? ($urandom_range(0, 3) != 0) : tog;
  endfunction

  task automatic chk(input string n, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      pending.delete();
      rdq.delete();
    end else begin
      if (read_addr_write) pending.push_back(read_addr_din);
      if (read_data_read && rdq.size() > 0) void'(rdq.pop_front());
    end
  end

  always @(posedge clk) begin
    logic g;
    #1;
    tog = ~tog;
    read_addr_full_n = mv(af_mode);
    out_full_n = mv(of_mode);
    g = mv(rd_mode);
    if (pending.size() > 0 && (g || rel_used < rel_cnt)) begin
      if (!g) rel_used++;
      rdq.push_back(dat(pending.pop_front()));
    end
    read_data_empty_n = rdq.size() > 0;
    read_data_dout = rdq.size() > 0 ? rdq[0] : '0;
  end

  always @(negedge clk) begin
    if (rst) begin
      exp_addr.delete();
      exp_data.delete();
      outst = 0;
      prev_ow = 0;
    end else begin
      if (read_addr_write) begin
        n_issue++;
        chk("outstanding_cap", 64'(outst < 64), 64'd1);
        chk("addr", read_addr_din, exp_addr.size() > 0 ? exp_addr.pop_front() : 64'hDEAD_0000_0000_DEAD);
      end
      if (out_write) begin
        n_beat++;
        chk("beat_handshake", {read_data_read, out_full_n, read_data_empty_n}, 3'b111);
        chk("data", out_din, exp_data.size() > 0 ? exp_data.pop_front() : {8{64'hDEAD_BEEF_DEAD_BEEF}});
      end
      if (done) begin
        n_done++;
        chk("done_busy_low", busy, 0);
        chk("done_after_last_beat", prev_ow, xfer_cnt != 0);
        chk("done_all_delivered", exp_addr.size() + exp_data.size(), 0);
      end
      outst = outst + int'(read_addr_write) - int'(read_data_read);
      prev_ow = out_write;
    end
  end

  task automatic go(input logic [63:0] b, input logic [31:0] c);
    start = 1;
    base_addr = b;
    count = c;
    xfer_cnt = c;
    for (int i = 0; i < int'(c); i++) begin
      exp_addr.push_back(b + 64'(i) * 64);
      exp_data.push_back(dat(b + 64'(i) * 64));
    end
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (done) begin
        n = i;
        break;
      end
    end
    if (n == 0) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int n, b0, i0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_strobes", {busy, done, read_addr_write, read_data_read, out_write}, 0);
    chk("reset_addr", read_addr_din, 0);
    @(posedge clk); #1;
    rst = 0;

    go(64'h1000, 4);
    wait_done(50, n);
    chk("t1_done_cycle", n, 6);

    rd_mode = 0;
    i0 = n_issue;
    go(64'h2_0000, 200);
    repeat (80) @(posedge clk);
    @(negedge clk);
    chk("t2_cap_issued", n_issue - i0, 64);
    chk("t2_cap_stalled", read_addr_write, 0);
    rel_cnt++;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("t2_one_more", n_issue - i0, 65);
    @(posedge clk); #1;
    rd_mode = 2;
    wait_done(3000, n);

    rd_mode = 1;
    of_mode = 3;
    b0 = n_beat;
    go(64'h40, 8);
    wait_done(100, n);
    chk("t3_beats", n_beat - b0, 8);
    of_mode = 1;

    go(64'hFFFF_FFFF_FFFF_FFC0, 2);
    wait_done(50, n);

    go(64'h5000, 0);
    wait_done(10, n);
    chk("t5_zero_done_cycle", n, 1);

    af_mode = 2; of_mode = 2; rd_mode = 2;
    b0 = n_beat;
    go(64'h7000, 5);
    @(posedge clk); #1;
    start = 1; base_addr = 64'h9999_0000; count = 9;
    @(posedge clk); #1;
    start = 0;
    wait_done(200, n);
    chk("t5_ignored_start_beats", n_beat - b0, 5);

    af_mode = 1; of_mode = 1; rd_mode = 1;
    b0 = n_beat;
    go(64'hA000, 10);
    for (int i = 0; i < 100 && n_beat - b0 < 3; i++) begin
      @(negedge clk); #1;
    end
    rst = 1;
    @(negedge clk);
    chk("t6_abort_strobes", {busy, done, read_addr_write, read_data_read, out_write}, 0);
    chk("t6_beats_before_abort", n_beat - b0, 3);
    @(posedge clk); #1;
    rst = 0;
    go(64'hB000, 2);
    wait_done(50, n);

    af_mode = 2; of_mode = 2; rd_mode = 2;
    for (int k = 0; k < 6; k++) begin
      go({$urandom, $urandom}, $urandom_range(1, 40));
      wait_done(2000, n);
    end
    chk("total_done_pulses", n_done, 13);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
